mem_access_unit: RTL

//  Initiator side of the word-addressed data-memory interface (mem_a/mem_we/mem_wd/mem_rd).

---
 rtl/mem_access_unit.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
// Data-memory initiator: accepts pipeline load/store requests and runs word-aligned memory cycles.
// Handles SB/SH by read-modify-write and LB/LH/LBU/LHU by lane extraction and extension.
module mem_access_unit #(
  parameter int unsigned ADDR_W        = 16,
  parameter bit          MISALIGN_TRAP = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_we,
  output logic [31:0]       mem_wd,
  input  logic [31:0]       mem_rd,
  output logic              busy
);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_RESP} state_e;

  state_e              state_q, state_d;
  logic                we_q, we_d;
  logic [2:0]          f3_q, f3_d;
  logic [1:0]          lane_q, lane_d;
  logic [15:0]         wdata_q, wdata_d;
  logic                req_ready_q, req_ready_d;
  logic                resp_valid_q, resp_valid_d;
  logic                resp_err_q, resp_err_d;
  logic [31:0]         resp_rdata_q, resp_rdata_d;
  logic [ADDR_W-1:0]   mem_a_q, mem_a_d;
  logic                mem_we_q, mem_we_d;
  logic [31:0]         mem_wd_q, mem_wd_d;
  logic                busy_q, busy_d;

  logic                req_illegal, req_misal;
  logic [ADDR_W-1:0]   req_eff_addr;
  logic [4:0]          byte_sh, half_sh;
  logic [7:0]          rd_byte;
  logic [15:0]         rd_half;
  logic [31:0]         load_val, merged;

  // Request decode: legality, alignment and the effective (possibly forced-aligned) address
  always_comb begin
    if (req_we) begin
      req_illegal = req_funct3[2] | (req_funct3[1:0] == 2'b11);
    end else begin
      req_illegal = (req_funct3 == 3'b011) | (req_funct3 == 3'b110) | (req_funct3 == 3'b111);
    end
    req_misal = MISALIGN_TRAP &&
                (((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                 ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00)));
    req_eff_addr = req_addr;
    if (!MISALIGN_TRAP) begin
      if (req_funct3[1:0] == 2'b01) req_eff_addr[0] = 1'b0;
      if (req_funct3[1:0] == 2'b10) req_eff_addr[1:0] = 2'b00;
    end
  end

  // Lane extraction for loads and lane merge for sub-word stores, little-endian
  always_comb begin
    byte_sh = {lane_q, 3'b000};
    half_sh = {lane_q[1], 4'b0000};
    rd_byte = mem_rd[byte_sh +: 8];
    rd_half = mem_rd[half_sh +: 16];
    case (f3_q[1:0])
      2'b00:   load_val = {{24{~f3_q[2] & rd_byte[7]}}, rd_byte};
      2'b01:   load_val = {{16{~f3_q[2] & rd_half[15]}}, rd_half};
      default: load_val = mem_rd;
    endcase
    merged = mem_rd;
    if (f3_q[1:0] == 2'b00) merged[byte_sh +: 8] = wdata_q[7:0];
    else                    merged[half_sh +: 16] = wdata_q;
  end

  // Next state and next registered outputs
  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    f3_d         = f3_q;
    lane_d       = lane_q;
    wdata_d      = wdata_q;
    mem_a_d      = mem_a_q;
    mem_wd_d     = '0;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready_q) begin
          we_d    = req_we;
          f3_d    = req_funct3;
          lane_d  = req_eff_addr[1:0];
          wdata_d = req_wdata[15:0];
          if (req_illegal || req_misal) begin
            state_d      = S_RESP;
            resp_rdata_d = '0;
            resp_err_d   = 1'b1;
          end else begin
            mem_a_d = {req_eff_addr[ADDR_W-1:2], 2'b00};
            if (req_we && (req_funct3[1:0] == 2'b10)) begin
              state_d  = S_WR;
              mem_wd_d = req_wdata;
            end else begin
              state_d = S_RD;
            end
          end
        end
      end
      S_RD: begin
        if (we_q) begin
          state_d  = S_WR;
          mem_wd_d = merged;
        end else begin
          state_d      = S_RESP;
          resp_rdata_d = load_val;
          resp_err_d   = 1'b0;
        end
      end
      S_WR: begin
        state_d      = S_RESP;
        resp_rdata_d = '0;
        resp_err_d   = 1'b0;
      end
      S_RESP: begin
        if (resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    req_ready_d  = (state_d == S_IDLE);
    resp_valid_d = (state_d == S_RESP);
    mem_we_d     = (state_d == S_WR);
    busy_d       = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      we_q         <= 1'b0;
      f3_q         <= '0;
      lane_q       <= '0;
      wdata_q      <= '0;
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
      mem_a_q      <= '0;
      mem_we_q     <= 1'b0;
      mem_wd_q     <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      f3_q         <= f3_d;
      lane_q       <= lane_d;
      wdata_q      <= wdata_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
      mem_a_q      <= mem_a_d;
      mem_we_q     <= mem_we_d;
      mem_wd_q     <= mem_wd_d;
      busy_q       <= busy_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;
  assign mem_a      = mem_a_q;
  assign mem_we     = mem_we_q;
  assign mem_wd     = mem_wd_q;
  assign busy       = busy_q;

endmodule
